vdiv_operand_seq: RTL

- Upstream sequencer for the 32-bit SIMD serial divider.
- Accepts one vector divide request (element count, element width, opcode), then streams packed 32-bit operand words from the operand queue.
- Emits one registered word per beat to the divider, with the per-word byte enable that blanks tail elements.
- Signals completion once the last word has been handed to the divider.

---
 rtl/vdiv_operand_seq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vdiv_operand_seq.sv
// Operand sequencer for the 32-bit SIMD serial divider: takes one vector divide
// request, streams packed operand words into a one-entry output register with tail byte enables.
package vdiv_operand_seq_pkg;
    typedef enum logic [1:0] {EW8 = 2'd0, EW16 = 2'd1, EW32 = 2'd2, EW64 = 2'd3} vew_e;
    typedef enum logic [1:0] {VDIVU = 2'd0, VDIV = 2'd1, VREMU = 2'd2, VREM = 2'd3} ara_op_e;
endpackage

module vdiv_operand_seq
    import vdiv_operand_seq_pkg::*;
#(
    parameter int VlWidth   = 16,
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [VlWidth-1:0]   req_vl_i,
    input  vew_e                 req_vew_i,
    input  ara_op_e              req_op_i,
    input  logic                 opnd_valid_i,
    output logic                 opnd_ready_o,
    input  logic [DataWidth-1:0] opnd_a_i,
    input  logic [DataWidth-1:0] opnd_b_i,
    input  logic [3:0]           opnd_mask_i,
    output logic [DataWidth-1:0] div_operand_a_o,
    output logic [DataWidth-1:0] div_operand_b_o,
    output logic [3:0]           div_mask_o,
    output logic [3:0]           div_be_o,
    output vew_e                 div_vew_o,
    output ara_op_e              div_op_o,
    output logic                 div_valid_o,
    input  logic                 div_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] ZERO  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]         state_q;
    logic [VlWidth-1:0] remaining_q;
    vew_e               vew_q;
    ara_op_e            op_q;

    logic [1:0]         vew_sh;
    logic [2:0]         epw;
    logic [1:0]         tail_bytes;
    logic [3:0]         be_next;
    logic [VlWidth-1:0] rem_next;
    logic               opnd_fire;
    logic               div_fire;
    vew_e               req_vew_eff;

    // The divider has no 64-bit mode; fold EW64 onto EW32 at request time.
    assign req_vew_eff = (req_vew_i == EW64) ? EW32 : req_vew_i;

    assign vew_sh = vew_q;
    assign epw    = 3'd4 >> vew_sh;

    // Tail only arises when fewer than epw elements remain, so remaining < 4 here.
    assign tail_bytes = 2'(remaining_q[1:0] << vew_sh);
    assign be_next    = (remaining_q >= VlWidth'(epw)) ? 4'hF
                                                       : 4'((5'd1 << tail_bytes) - 5'd1);
    assign rem_next   = (remaining_q > VlWidth'(epw)) ? remaining_q - VlWidth'(epw) : '0;

    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign opnd_ready_o = (state_q == RUN) && (!div_valid_o || div_ready_i);
    assign opnd_fire    = opnd_valid_i && opnd_ready_o;
    assign div_fire     = div_valid_o && div_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            remaining_q     <= '0;
            vew_q           <= EW8;
            op_q            <= VDIV;
            div_operand_a_o <= '0;
            div_operand_b_o <= '0;
            div_mask_o      <= '0;
            div_be_o        <= '0;
            div_vew_o       <= EW8;
            div_op_o        <= VDIV;
            div_valid_o     <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        vew_q       <= req_vew_eff;
                        op_q        <= req_op_i;
                        remaining_q <= req_vl_i;
                        if (req_vl_i != '0) begin
                            state_q <= RUN;
                        end else begin
                            state_q <= ZERO;
                            done_o  <= 1'b1;
                        end
                    end
                end
                ZERO: state_q <= IDLE;
                RUN: begin
                    // A load in the same cycle as a divider handshake simply replaces the word.
                    if (opnd_fire) begin
                        div_operand_a_o <= opnd_a_i;
                        div_operand_b_o <= opnd_b_i;
                        div_mask_o      <= opnd_mask_i;
                        div_be_o        <= be_next;
                        div_vew_o       <= vew_q;
                        div_op_o        <= op_q;
                        div_valid_o     <= 1'b1;
                        remaining_q     <= rem_next;
                        if (rem_next == '0) state_q <= DRAIN;
                    end else if (div_fire) begin
                        div_valid_o <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (div_fire) begin
                        div_valid_o <= 1'b0;
                        done_o      <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
